mini_cpu_core_p: RTL and testbench

- Parametrised successor to the mini-CPU control unit, with an integrated register file, ALU and writeback.
- Accepts one instruction per handshake from the switch/button front end and runs it through a FETCH/EXECUTE/STORE state machine.
- Adds iterative signed multiply, multi-cycle register-file CLEAR, an overflow flag and a busy/done handshake.
- Drives the LCD/display front end through result, result_addr and last_opcode.

---
 rtl/mini_cpu_core_p.sv | 245 ++++++++++++++++++++++++
 tb/tb_mini_cpu_core_p.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mini_cpu_core_p.sv
// Mini-CPU core: instruction latch, FETCH/EXEC/STORE control, register file,
// ALU, iterative signed multiply and multi-cycle register-file clear.
module mini_cpu_core_p #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RA_W    = 4,
  parameter int unsigned INSTR_W = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic [RA_W-1:0]    result_addr,
  output logic               overflow,
  output logic [2:0]         last_opcode
);

  localparam int unsigned IMM_W    = INSTR_W - 3 - 2*RA_W;
  localparam int unsigned NUM_REGS = 2**RA_W;
  localparam int unsigned MCNT_W   = $clog2(DATA_W);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_EXEC     = 3'd2;
  localparam logic [2:0] S_MUL_ITER = 3'd3;
  localparam logic [2:0] S_CLR_ITER = 3'd4;
  localparam logic [2:0] S_STORE    = 3'd5;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_ADDI  = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_SUBI  = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_DISP  = 3'b111;

  logic [2:0]          state_q, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                ovf_q, ovf_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic                neg_q, neg_d;
  logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
  logic [RA_W-1:0]     clr_q, clr_d;

  logic [DATA_W-1:0]   result_q, result_d;
  logic [RA_W-1:0]     result_addr_q, result_addr_d;
  logic                ovf_out_q, ovf_out_d;
  logic [2:0]          last_op_q, last_op_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic                rf_we;
  logic [RA_W-1:0]     rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;

  logic [2:0]          opc;
  logic [RA_W-1:0]     dst, src1, src2;
  logic [IMM_W-1:0]    imm;
  logic [DATA_W-1:0]   imm_sext;
  logic [DATA_W-1:0]   b_sel, sum, diff, a_mag, b_mag;
  logic [2*DATA_W-1:0] prod_s;
  logic                mul_ovf;
  logic [DATA_W-1:0]   store_val;
  logic                store_ovf;

  assign opc      = instr_q[INSTR_W-1 -: 3];
  assign dst      = instr_q[INSTR_W-4 -: RA_W];
  assign src1     = instr_q[INSTR_W-4-RA_W -: RA_W];
  assign imm      = instr_q[IMM_W-1:0];
  assign src2     = imm[IMM_W-1 -: RA_W];
  assign imm_sext = DATA_W'($signed(imm));

  assign b_sel = (opc == OP_ADD || opc == OP_SUB) ? op_b_q : imm_sext;
  assign sum   = op_a_q + b_sel;
  assign diff  = op_a_q - b_sel;
  // Magnitudes stay DATA_W wide unsigned, so the most negative value maps to itself.
  assign a_mag = op_a_q[DATA_W-1] ? (~op_a_q + 1'b1) : op_a_q;
  assign b_mag = b_sel[DATA_W-1]  ? (~b_sel + 1'b1)  : b_sel;

  assign prod_s  = neg_q ? (~prod_q + 1'b1) : prod_q;
  assign mul_ovf = ~((&prod_s[2*DATA_W-1:DATA_W-1]) | ~(|prod_s[2*DATA_W-1:DATA_W-1]));

  assign store_val = (opc == OP_MUL) ? prod_s[DATA_W-1:0] : res_q;
  assign store_ovf = (opc == OP_MUL) ? mul_ovf : ovf_q;

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    res_d         = res_q;
    ovf_d         = ovf_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    prod_d        = prod_q;
    neg_d         = neg_q;
    mcnt_d        = mcnt_q;
    clr_d         = clr_q;
    result_d      = result_q;
    result_addr_d = result_addr_q;
    ovf_out_d     = ovf_out_q;
    last_op_d     = last_op_q;
    done_d        = 1'b0;
    rf_we         = 1'b0;
    rf_waddr      = dst;
    rf_wdata      = store_val;

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        op_a_d  = regs_q[src1];
        op_b_d  = regs_q[src2];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_STORE;
        case (opc)
          OP_LOAD: begin
            res_d = imm_sext;
            ovf_d = 1'b0;
          end
          OP_ADD, OP_ADDI: begin
            res_d = sum;
            ovf_d = (op_a_q[DATA_W-1] == b_sel[DATA_W-1]) && (sum[DATA_W-1] != op_a_q[DATA_W-1]);
          end
          OP_SUB, OP_SUBI: begin
            res_d = diff;
            ovf_d = (op_a_q[DATA_W-1] != b_sel[DATA_W-1]) && (diff[DATA_W-1] != op_a_q[DATA_W-1]);
          end
          OP_MUL: begin
            mcand_d  = {{DATA_W{1'b0}}, a_mag};
            mplier_d = b_mag;
            prod_d   = '0;
            neg_d    = op_a_q[DATA_W-1] ^ b_sel[DATA_W-1];
            mcnt_d   = '0;
            state_d  = S_MUL_ITER;
          end
          OP_CLEAR: begin
            res_d   = '0;
            ovf_d   = 1'b0;
            clr_d   = '0;
            state_d = S_CLR_ITER;
          end
          default: begin
            res_d = op_a_q;
            ovf_d = 1'b0;
          end
        endcase
      end
      S_MUL_ITER: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        mcnt_d   = mcnt_q + 1'b1;
        if (mcnt_q == MCNT_W'(DATA_W-1)) state_d = S_STORE;
      end
      S_CLR_ITER: begin
        rf_we    = 1'b1;
        rf_waddr = clr_q;
        rf_wdata = '0;
        clr_d    = clr_q + 1'b1;
        if (clr_q == '1) state_d = S_STORE;
      end
      S_STORE: begin
        rf_we         = (opc != OP_CLEAR) && (opc != OP_DISP);
        result_d      = store_val;
        result_addr_d = (opc == OP_DISP) ? src1 : ((opc == OP_CLEAR) ? '0 : dst);
        ovf_out_d     = store_ovf;
        last_op_d     = opc;
        done_d        = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      res_q         <= '0;
      ovf_q         <= 1'b0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      prod_q        <= '0;
      neg_q         <= 1'b0;
      mcnt_q        <= '0;
      clr_q         <= '0;
      result_q      <= '0;
      result_addr_q <= '0;
      ovf_out_q     <= 1'b0;
      last_op_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      res_q         <= res_d;
      ovf_q         <= ovf_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      prod_q        <= prod_d;
      neg_q         <= neg_d;
      mcnt_q        <= mcnt_d;
      clr_q         <= clr_d;
      result_q      <= result_d;
      result_addr_q <= result_addr_d;
      ovf_out_q     <= ovf_out_d;
      last_op_q     <= last_op_d;
      done_q        <= done_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign result_addr = result_addr_q;
  assign overflow    = ovf_out_q;
  assign last_opcode = last_op_q;

endmodule

// File: tb/tb_mini_cpu_core_p.sv
// Randomized self-checking bench for mini_cpu_core_p against an arithmetic
// reference model of the instruction set and its latencies.
module tb_mini_cpu_core_p;

  localparam int DW  = 16;
  localparam int RW  = 4;
  localparam int IW  = 18;
  localparam int NR  = 16;
  localparam longint MAXV = (64'sd1 <<< (DW-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (DW-1));

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic          busy, done, overflow;
  logic [DW-1:0] result;
  logic [RW-1:0] result_addr;
  logic [2:0]    last_opcode;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mregs [NR];

  mini_cpu_core_p #(.DATA_W(DW), .RA_W(RW), .INSTR_W(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .result_addr (result_addr),
    .overflow    (overflow),
    .last_opcode (last_opcode)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] enc_r(input logic [2:0] op, input logic [3:0] d,
                                          input logic [3:0] s1, input logic [3:0] s2);
    return {op, d, s1, s2, 3'b000};
  endfunction

  function automatic logic [IW-1:0] enc_i(input logic [2:0] op, input logic [3:0] d,
                                          input logic [3:0] s1, input logic [6:0] im);
    return {op, d, s1, im};
  endfunction

  function automatic longint sx(input logic [DW-1:0] v);
    logic signed [DW-1:0] t;
    t = v;
    return longint'(t);
  endfunction

  // Reference: architectural effect of one instruction plus its accept-to-done latency.
  task automatic model_exec(input logic [IW-1:0] ins, output logic [DW-1:0] er,
                            output logic [RW-1:0] ea, output logic eo, output int lat);
    logic [2:0] op;
    logic [3:0] d, s1, s2;
    logic signed [6:0] im7;
    longint a, b, r, im;
    op  = ins[17:15];
    d   = ins[14:11];
    s1  = ins[10:7];
    s2  = ins[6:3];
    im7 = ins[6:0];
    im  = longint'(im7);
    a   = sx(mregs[s1]);
    b   = sx(mregs[s2]);
    r   = 0;
    eo  = 1'b0;
    ea  = d;
    lat = 4;
    case (op)
      3'd0: r = im;
      3'd1: r = a + b;
      3'd2: r = a + im;
      3'd3: r = a - b;
      3'd4: r = a - im;
      3'd5: begin r = a * im; lat = 4 + DW; end
      3'd6: begin r = 0; ea = '0; lat = 4 + NR; end
      default: begin r = a; ea = s1; end
    endcase
    if (op >= 3'd1 && op <= 3'd5) eo = (r > MAXV) || (r < MINV);
    er = DW'(r);
    if (op == 3'd6) begin
      for (int i = 0; i < NR; i++) mregs[i] = '0;
    end else if (op != 3'd7) begin
      mregs[d] = er;
    end
  endtask

  // Caller guarantees the DUT is idle at the sample point when this is entered.
  task automatic run_instr(input logic [IW-1:0] ins, input bit noise);
    logic [DW-1:0] er;
    logic [RW-1:0] ea;
    logic eo;
    int lat, n, bcnt;
    model_exec(ins, er, ea, eo, lat);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr       = IW'($urandom);
    n    = 1;
    bcnt = 0;
    while (!done && n < 64) begin
      if (busy) bcnt++;
      if (noise && busy && $urandom_range(0, 2) == 0) begin
        instr_valid = 1'b1;
        instr       = IW'($urandom);
      end
      @(posedge clk); #1;
      instr_valid = 1'b0;
      n++;
    end
    check_eq("done_seen", 32'(done), 32'd1);
    check_eq("latency", n, lat);
    check_eq("busy_cycles", bcnt, lat - 1);
    check_eq("busy_in_done", 32'(busy), 32'd0);
    check_eq("result", 32'(result), 32'(er));
    check_eq("result_addr", 32'(result_addr), 32'(ea));
    check_eq("overflow", 32'(overflow), 32'(eo));
    check_eq("last_opcode", 32'(last_opcode), 32'(ins[17:15]));
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
      check_eq("done_pulse_width", 32'(done), 32'd0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_result"}, 32'(result), 32'd0);
    check_eq({tag, "_addr"}, 32'(result_addr), 32'd0);
    check_eq({tag, "_ovf"}, 32'(overflow), 32'd0);
    check_eq({tag, "_lastop"}, 32'(last_opcode), 32'd0);
  endtask

  task automatic reset_mid_mul();
    int k;
    instr       = enc_i(3'd5, 4'd6, 4'd5, 7'h7E);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    k = $urandom_range(3, 12);
    repeat (k) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check_idle_outputs("rst_mid_mul");
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("rst_hold_done", 32'(done), 32'd0);
    end
    reset = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      check_eq("post_rst_no_done", 32'(done), 32'd0);
    end
    run_instr(enc_r(3'd7, 4'd0, 4'd6, 4'd0), 1'b0);
  endtask

  initial begin
    logic [IW-1:0] ins;
    reset       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    run_instr(enc_i(3'd0, 4'd1, 4'd0, 7'd5), 1'b0);
    run_instr(enc_i(3'd0, 4'd2, 4'd0, 7'h7D), 1'b0);
    run_instr(enc_r(3'd1, 4'd3, 4'd1, 4'd2), 1'b0);
    run_instr(enc_r(3'd3, 4'd4, 4'd2, 4'd1), 1'b1);
    run_instr(enc_r(3'd7, 4'd0, 4'd3, 4'd0), 1'b0);

    run_instr(enc_i(3'd0, 4'd5, 4'd0, 7'd63), 1'b0);
    for (int i = 0; i < 10; i++) run_instr(enc_r(3'd1, 4'd5, 4'd5, 4'd5), 1'b1);

    run_instr(enc_i(3'd0, 4'd5, 4'd0, 7'd7), 1'b0);
    run_instr(enc_i(3'd5, 4'd6, 4'd5, 7'h7E), 1'b1);
    run_instr(enc_i(3'd0, 4'd5, 4'd0, 7'd1), 1'b0);
    for (int i = 0; i < 14; i++) run_instr(enc_r(3'd1, 4'd5, 4'd5, 4'd5), 1'b0);
    run_instr(enc_i(3'd5, 4'd6, 4'd5, 7'h7E), 1'b0);
    run_instr(enc_i(3'd5, 4'd7, 4'd5, 7'd2), 1'b0);
    run_instr(enc_i(3'd5, 4'd8, 4'd5, 7'h40), 1'b0);

    run_instr(enc_r(3'd6, 4'd0, 4'd0, 4'd0), 1'b1);
    for (int r = 1; r < NR; r++) run_instr(enc_r(3'd7, 4'd0, 4'(r), 4'd0), 1'b0);

    for (int r = 0; r < NR; r++) run_instr(enc_i(3'd0, 4'(r), 4'd0, 7'($urandom)), 1'b0);
    reset_mid_mul();

    for (int t = 0; t < 150; t++) begin
      ins = IW'($urandom);
      if (ins[17:15] == 3'd6 && $urandom_range(0, 3) != 0) ins[17:15] = 3'd2;
      run_instr(ins, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    for (int r = 0; r < NR; r++) run_instr(enc_r(3'd7, 4'd0, 4'(r), 4'd0), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
